// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment pattern sequencer:
//   - seg_t   : one digit's segments {g,f,e,d,c,b,a}, active-low
//   - G0/G1/G2/GERR/BLANK glyph constants
//   - mode_e  : mode encoding of the sequencer's mode input
//   - glyph() : maps a glyph number 0..2 onto its segment pattern
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t G0    = 7'b0000000;
    localparam seg_t G1    = 7'b0010010;
    localparam seg_t G2    = 7'b1011000;
    localparam seg_t GERR  = 7'b1000000;
    localparam seg_t BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_BLANK  = 2'b11
    } mode_e;

    function automatic seg_t glyph(input logic [1:0] g);
        seg_t r;
        case (g)
            2'd0:    r = G0;
            2'd1:    r = G1;
            default: r = G2;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_tick_div.sv
// ---------------------------------------------------------------------------
// seg_tick_div
// Free-running divider that counts 0..DIV-1 and flags the last count as a
// tick. A clear input forces the count back to 0 and suppresses the tick in
// that same cycle, so leaving the counting mode on a tick cycle never
// produces an advance.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clr_i  in  synchronous clear (also masks tick_o)
//   tick_o out high during the cycle the count equals DIV-1
// ---------------------------------------------------------------------------
module seg_tick_div #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/seg_pattern_seq.sv
// ---------------------------------------------------------------------------
// seg_pattern_seq
// Seven-segment pattern sequencer. Holds a step index and renders a
// generated glyph pattern on DIGITS active-low digits. Digit d at step s
// shows glyph ((s mod 3) + d*(s div 3)) mod 3.
// Modes: 00 direct select, 01 auto-run from the tick divider,
//        10 single-step from a synchronised push-button, 11 blank.
// Optional feature macro: SEG_BLINK_EN -- when defined, mode 11 alternates
// the current pattern with BLANK on every tick (pattern phase first);
// otherwise mode 11 is steady BLANK.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   sel   in   [3:0] direct step select (mode 00)
//   mode  in   [1:0] operating mode
//   step  in   raw asynchronous push-button level, active-high
//   seg   out  [7*DIGITS-1:0] segments, digit 0 in the top 7 bits
//   idx   out  [3:0] current step index
//   wrap  out  one-cycle pulse when idx advances from STEPS-1 to 0
// ---------------------------------------------------------------------------
module seg_pattern_seq
    import seg_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int STEPS  = 6,
    parameter int DIV    = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            sel,
    input  logic [1:0]            mode,
    input  logic                  step,
    output logic [7*DIGITS-1:0]   seg,
    output logic [3:0]            idx,
    output logic                  wrap
);

    localparam logic [3:0]          LAST_IDX  = 4'(STEPS - 1);
    localparam logic [7*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK}};
    localparam logic [7*DIGITS-1:0] ALL_ERR   = {DIGITS{GERR}};

    mode_e mode_w;
    assign mode_w = mode_e'(mode);

    // Push-button path: two synchroniser flops, then an edge register so a
    // held button yields a single rising-edge pulse.
    logic sync1_q, sync2_q, step_prev_q;
    logic step_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            sync1_q     <= step;
            sync2_q     <= sync1_q;
            step_prev_q <= sync2_q;
        end
    end

    assign step_rise = sync2_q & ~step_prev_q;

    // Tick divider; it only runs while a mode that consumes ticks is active.
    logic cnt_clr;
    logic tick;

`ifdef SEG_BLINK_EN
    assign cnt_clr = !((mode_w == MODE_AUTO) || (mode_w == MODE_BLANK));
`else
    assign cnt_clr = (mode_w != MODE_AUTO);
`endif

    seg_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .tick_o (tick)
    );

    function automatic logic [7*DIGITS-1:0] render(input logic [3:0] s);
        logic [7*DIGITS-1:0] r;
        int s_mod;
        int s_div;
        int g;
        r     = '0;
        s_mod = int'(s) % 3;
        s_div = int'(s) / 3;
        for (int d = 0; d < DIGITS; d++) begin
            g = (s_mod + d * s_div) % 3;
            r[7*(DIGITS-d)-1 -: 7] = glyph(2'(g));
        end
        return r;
    endfunction

    logic [3:0]          idx_q, idx_d;
    logic                err_q, err_d;
    logic                wrap_q, wrap_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                adv;
    logic [7*DIGITS-1:0] pattern;

`ifdef SEG_BLINK_EN
    logic blink_q, blink_d;
`endif

    // Index / error next-state
    always_comb begin
        idx_d  = idx_q;
        err_d  = 1'b0;
        wrap_d = 1'b0;
        adv    = 1'b0;
`ifdef SEG_BLINK_EN
        blink_d = 1'b0;
`endif
        case (mode_w)
            MODE_DIRECT: begin
                // Out-of-range selects keep the old index and flag the error.
                if (sel <= LAST_IDX) begin
                    idx_d = sel;
                end else begin
                    err_d = 1'b1;
                end
            end
            MODE_AUTO:  adv = tick;
            MODE_STEP:  adv = step_rise;
            MODE_BLANK: begin
`ifdef SEG_BLINK_EN
                blink_d = blink_q ^ tick;
`endif
            end
            default: ;
        endcase

        if (adv) begin
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    // Segment image, registered one cycle behind idx/err
    always_comb begin
        pattern = render(idx_q);
        seg_d   = err_q ? ALL_ERR : pattern;
        if (mode_w == MODE_BLANK) begin
`ifdef SEG_BLINK_EN
            seg_d = blink_q ? ALL_BLANK : pattern;
`else
            seg_d = ALL_BLANK;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
            seg_q  <= ALL_BLANK;
        end else begin
            idx_q  <= idx_d;
            err_q  <= err_d;
            wrap_q <= wrap_d;
            seg_q  <= seg_d;
        end
    end

`ifdef SEG_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    assign seg  = seg_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_pattern_seq.sv
// ---------------------------------------------------------------------------
// tb_seg_pattern_seq
// Self-checking bench for seg_pattern_seq (DIGITS=2, STEPS=6, DIV=4).
// A behavioural model tracks index, error flag, run length in the counting
// mode and the recent push-button history, and predicts idx/seg/wrap after
// every clock edge. Table-driven direct-select vectors and hand-written
// multi-cycle sequences add fixed expectations on top.
// ---------------------------------------------------------------------------
module tb_seg_pattern_seq;

    localparam int DIGITS = 2;
    localparam int STEPS  = 6;
    localparam int DIV    = 4;
    localparam int SW     = 7 * DIGITS;

`ifdef SEG_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] T_G0    = 7'b0000000;
    localparam logic [6:0] T_G1    = 7'b0010010;
    localparam logic [6:0] T_G2    = 7'b1011000;
    localparam logic [6:0] T_GERR  = 7'b1000000;
    localparam logic [6:0] T_BLANK = 7'b1111111;
    localparam logic [SW-1:0] T_ALL_BLANK = {DIGITS{T_BLANK}};
    localparam logic [SW-1:0] T_ALL_ERR   = {DIGITS{T_GERR}};

    logic          clk;
    logic          rst_n;
    logic [3:0]    sel;
    logic [1:0]    mode;
    logic          step;
    logic [SW-1:0] seg;
    logic [3:0]    idx;
    logic          wrap;

    int checks   = 0;
    int failures = 0;

    seg_pattern_seq #(
        .DIGITS (DIGITS),
        .STEPS  (STEPS),
        .DIV    (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .mode  (mode),
        .step  (step),
        .seg   (seg),
        .idx   (idx),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int            m_idx;
    bit            m_err;
    bit            m_wrap;
    logic [SW-1:0] m_seg;
    int            m_run;      // consecutive past edges spent in a counting mode
    bit            s_hist[3];  // step level at the last three edges, newest first

    function automatic logic [6:0] glyph_of(input int k);
        case (k)
            0:       return T_G0;
            1:       return T_G1;
            default: return T_G2;
        endcase
    endfunction

    function automatic logic [SW-1:0] pattern_of(input int s);
        logic [SW-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[SW-1-7*d -: 7] = glyph_of(((s % 3) + d * (s / 3)) % 3);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_err  = 0;
        m_wrap = 0;
        m_seg  = T_ALL_BLANK;
        m_run  = 0;
        for (int i = 0; i < 3; i++) s_hist[i] = 0;
    endtask

    task automatic model_edge();
        bit counting;
        bit tick;
        bit rise;
        bit adv;
        int m;
        m        = int'(mode);
        counting = (m == 1) || (BLINK && m == 3);
        tick     = counting && ((m_run % DIV) == DIV - 1);
        rise     = s_hist[1] && !s_hist[2];

        if (m == 3) begin
            m_seg = (BLINK && ((m_run / DIV) % 2 == 0)) ? pattern_of(m_idx) : T_ALL_BLANK;
        end else begin
            m_seg = m_err ? T_ALL_ERR : pattern_of(m_idx);
        end

        adv    = (m == 1 && tick) || (m == 2 && rise);
        m_wrap = adv && (m_idx == STEPS - 1);
        if (adv) m_idx = (m_idx + 1) % STEPS;

        if (m == 0) begin
            if (int'(sel) < STEPS) begin
                m_idx = int'(sel);
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_err = 0;
        end

        m_run     = counting ? m_run + 1 : 0;
        s_hist[2] = s_hist[1];
        s_hist[1] = s_hist[0];
        s_hist[0] = step;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_idx",  32'(idx),  32'(m_idx));
        chk("model_seg",  32'(seg),  32'(m_seg));
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // ---------------- direct-select vectors ----------------
    typedef struct {
        logic [3:0]    sel;
        logic [3:0]    exp_idx;
        logic [SW-1:0] exp_seg;
    } dvec_t;

    dvec_t dtab[8];

    initial begin
        dtab[0] = '{4'd3,  4'd3, {T_G0,   T_G1}};
        dtab[1] = '{4'd5,  4'd5, {T_G2,   T_G0}};
        dtab[2] = '{4'd7,  4'd5, {T_GERR, T_GERR}};
        dtab[3] = '{4'd0,  4'd0, {T_G0,   T_G0}};
        dtab[4] = '{4'd1,  4'd1, {T_G1,   T_G1}};
        dtab[5] = '{4'd4,  4'd4, {T_G1,   T_G2}};
        dtab[6] = '{4'd2,  4'd2, {T_G2,   T_G2}};
        dtab[7] = '{4'd15, 4'd2, {T_GERR, T_GERR}};

        rst_n = 1'b0;
        mode  = 2'b01;
        sel   = 4'd0;
        step  = 1'b0;
        model_reset();

        // Reset held across edges with auto-run selected
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_seg",  32'(seg),  32'(T_ALL_BLANK));
            chk("rst_idx",  32'(idx),  32'd0);
            chk("rst_wrap", 32'(wrap), 32'd0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int n = 1; n <= 4; n++) begin
            cyc();
            chk("rst_first_adv", 32'(idx), (n == 4) ? 32'd1 : 32'd0);
        end

        // Direct select table
        mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            sel = dtab[i].sel;
            cycles(2);
            chk("direct_idx",  32'(idx),  32'(dtab[i].exp_idx));
            chk("direct_seg",  32'(seg),  32'(dtab[i].exp_seg));
            chk("direct_wrap", 32'(wrap), 32'd0);
        end

        // Auto-run wrap: idx 0,1,..,5,0 every DIV cycles, single wrap pulse
        sel = 4'd0;
        cycles(2);
        mode = 2'b01;
        for (int n = 1; n <= 28; n++) begin
            cyc();
            chk("auto_idx",  32'(idx),  32'((n / DIV) % STEPS));
            chk("auto_wrap", 32'(wrap), (n == DIV * STEPS) ? 32'd1 : 32'd0);
        end

        // Single-step: held button advances once, 3 edges after rising
        mode = 2'b00;
        sel  = 4'd2;
        cycles(2);
        mode = 2'b10;
        cycles(3);
        step = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            chk("step_idx", 32'(idx), (n >= 3) ? 32'd3 : 32'd2);
            if (n == 4) chk("step_seg", 32'(seg), 32'({T_G0, T_G1}));
        end
        step = 1'b0;
        cycles(4);

        // Step pulse while auto-running adds no advance
        mode = 2'b00;
        sel  = 4'd0;
        cycles(2);
        mode = 2'b01;
        for (int n = 1; n <= 12; n++) begin
            step = (n >= 2 && n <= 4);
            cyc();
            chk("auto_step_idx", 32'(idx), 32'((n / DIV) % STEPS));
        end
        step = 1'b0;

        // Mode 11 from idx 2
        mode = 2'b00;
        sel  = 4'd2;
        cycles(2);
        mode = 2'b11;
        for (int n = 1; n <= 16; n++) begin
            cyc();
            if (BLINK && (((n - 1) / DIV) % 2 == 0))
                chk("blank_seg", 32'(seg), 32'({T_G2, T_G2}));
            else
                chk("blank_seg", 32'(seg), 32'(T_ALL_BLANK));
            chk("blank_idx",  32'(idx),  32'd2);
            chk("blank_wrap", 32'(wrap), 32'd0);
        end

        // Asynchronous reset between edges during auto-run
        mode = 2'b00;
        sel  = 4'd0;
        cycles(2);
        mode = 2'b01;
        cycles(9);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_seg",  32'(seg),  32'(T_ALL_BLANK));
        chk("async_idx",  32'(idx),  32'd0);
        chk("async_wrap", 32'(wrap), 32'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
        cycles(6);

        // Randomised traffic against the model
        for (int seg_i = 0; seg_i < 250; seg_i++) begin
            int nm;
            int len;
            nm = $urandom_range(0, 3);
            if (BLINK && ((mode == 2'b01 && nm == 3) || (mode == 2'b11 && nm == 1))) nm = 0;
            mode = 2'(nm);
            sel  = 4'($urandom_range(0, 15));
            len  = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 3) == 0) step = ~step;
                if ($urandom_range(0, 5) == 0) sel = 4'($urandom_range(0, 15));
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
